sm_step_output: RTL and testbench

Output conditioning stage placed directly downstream of the stepper-motor pulse generator. It consumes the generator's `drv_pulse` stream and drives the external step/dir/enable pins of the SM driver IC. It enforces the driver's minimum step high/low widths, direction-setup time and enable wake-up delay. It keeps a signed position count, counts dropped steps, and latches driver faults.

---
 rtl/sm_step_output_if.sv | 29 ++
 rtl/sm_step_output.sv | 209 ++++++++++++++++++++
 tb/tb_sm_step_output.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_step_output_if.sv
// Pin bundle between the pulse generator / host side and the step output stage.
// The master side drives requests; the slave side (the output stage) drives the pins and status.
interface sm_step_output_if #(
    parameter int POS_W = 32
);
    logic             step_in;
    logic             dir_req;
    logic             en_req;
    logic             fault_n;
    logic             fault_clr;
    logic             clr_pos;
    logic             step_out;
    logic             dir_out;
    logic             en_out;
    logic [POS_W-1:0] position;
    logic [7:0]       drop_cnt;
    logic             fault_latched;
    logic             busy;

    modport master (
        output step_in, dir_req, en_req, fault_n, fault_clr, clr_pos,
        input  step_out, dir_out, en_out, position, drop_cnt, fault_latched, busy
    );

    modport slave (
        input  step_in, dir_req, en_req, fault_n, fault_clr, clr_pos,
        output step_out, dir_out, en_out, position, drop_cnt, fault_latched, busy
    );
endinterface

// File: rtl/sm_step_output.sv
// Stepper driver output conditioning: enforces step high/low widths, direction setup and
// enable wake-up time, tracks signed position, counts dropped steps and latches driver faults.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// DISABLED | driver off, step requests ignored
// WAKE     | en_out high, waiting EN_DELAY cycles before the first step
// IDLE     | enabled, no step in flight
// DIR_SET  | dir_out just changed, waiting DIR_SETUP cycles
// HIGH     | step_out high for MIN_HIGH cycles
// LOW      | step_out low for MIN_LOW cycles
// FAULT    | driver fault seen, outputs off until fault_clr
module sm_step_output #(
    parameter int POS_W     = 32,
    parameter int MIN_HIGH  = 100,
    parameter int MIN_LOW   = 100,
    parameter int DIR_SETUP = 250,
    parameter int EN_DELAY  = 500
) (
    input  logic              clk,
    input  logic              rst,
    sm_step_output_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_WAKE,
        ST_IDLE,
        ST_DIR_SET,
        ST_HIGH,
        ST_LOW,
        ST_FAULT
    } state_t;

    localparam logic [15:0] HIGH_LD = 16'(MIN_HIGH - 1);
    localparam logic [15:0] LOW_LD  = 16'(MIN_LOW - 1);
    localparam logic [15:0] DIR_LD  = 16'(DIR_SETUP - 1);
    localparam logic [15:0] WAKE_LD = 16'(EN_DELAY - 1);

    state_t           state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic             pending_q, pending_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [7:0]       drop_q, drop_d;
    logic             step_prev_q, step_prev_d;
    logic             flt_meta_q, flt_meta_d;
    logic             flt_sync_q, flt_sync_d;

    logic step_edge;
    logic flt;
    logic timer_tc;
    logic launch;
    logic absorb;
    logic pos_inc;

    assign step_edge = bus.step_in & ~step_prev_q;
    assign flt       = flt_sync_q;
    assign timer_tc  = (timer_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pending_d   = pending_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        drop_d      = drop_q;
        step_prev_d = bus.step_in;
        flt_meta_d  = ~bus.fault_n;
        flt_sync_d  = flt_meta_q;
        launch      = 1'b0;
        absorb      = 1'b0;
        pos_inc     = 1'b0;

        if (flt) begin
            state_d   = ST_FAULT;
            pending_d = 1'b0;
        end else if (state_q == ST_FAULT) begin
            if (bus.fault_clr) begin
                state_d = ST_DISABLED;
            end
        end else if (!bus.en_req) begin
            state_d   = ST_DISABLED;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_WAKE;
                    timer_d = WAKE_LD;
                end
                ST_WAKE: begin
                    if (step_edge) begin
                        pending_d = 1'b1;
                    end
                    if (timer_tc) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_IDLE: begin
                    if (step_edge || pending_q) begin
                        launch    = 1'b1;
                        pending_d = step_edge & pending_q;
                    end
                end
                ST_DIR_SET: begin
                    absorb = 1'b1;
                    if (timer_tc) begin
                        state_d = ST_HIGH;
                        timer_d = HIGH_LD;
                        pos_inc = 1'b1;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_HIGH: begin
                    absorb = 1'b1;
                    if (timer_tc) begin
                        state_d = ST_LOW;
                        timer_d = LOW_LD;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
                ST_LOW: begin
                    // The last LOW cycle hands straight over to the next step, so
                    // back-to-back requests run at exactly MIN_HIGH+MIN_LOW.
                    if (timer_tc) begin
                        if (step_edge || pending_q) begin
                            launch    = 1'b1;
                            pending_d = step_edge & pending_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        absorb  = 1'b1;
                        timer_d = timer_q - 16'd1;
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end

        if (absorb && step_edge) begin
            if (pending_q) begin
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end else begin
                pending_d = 1'b1;
            end
        end

        if (launch) begin
            if (bus.dir_req != dir_q) begin
                dir_d   = bus.dir_req;
                state_d = ST_DIR_SET;
                timer_d = DIR_LD;
            end else begin
                state_d = ST_HIGH;
                timer_d = HIGH_LD;
                pos_inc = 1'b1;
            end
        end

        if (bus.clr_pos) begin
            pos_d = '0;
        end else if (pos_inc) begin
            pos_d = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_DISABLED;
            timer_q     <= 16'd0;
            pending_q   <= 1'b0;
            dir_q       <= 1'b0;
            pos_q       <= '0;
            drop_q      <= 8'd0;
            step_prev_q <= 1'b0;
            flt_meta_q  <= 1'b0;
            flt_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            drop_q      <= drop_d;
            step_prev_q <= step_prev_d;
            flt_meta_q  <= flt_meta_d;
            flt_sync_q  <= flt_sync_d;
        end
    end

    assign bus.step_out      = (state_q == ST_HIGH);
    assign bus.en_out        = (state_q != ST_DISABLED) && (state_q != ST_FAULT);
    assign bus.dir_out       = dir_q;
    assign bus.position      = pos_q;
    assign bus.drop_cnt      = drop_q;
    assign bus.fault_latched = (state_q == ST_FAULT);
    assign bus.busy          = (state_q == ST_DIR_SET) || (state_q == ST_HIGH) ||
                               (state_q == ST_LOW) || pending_q;

endmodule

// File: tb/tb_sm_step_output.sv
// Bench for sm_step_output: directed table and sequences on a full-size instance,
// randomized traffic on a small-parameter instance against an event-schedule model.
module tb_sm_step_output;

    localparam int MH = 100, ML = 100, DS = 250, ED = 500;
    localparam int S_MH = 2, S_ML = 2, S_DS = 3, S_ED = 4, S_W = 4;
    localparam int N_RAND = 12000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sm_step_output_if #(.POS_W(32))  bus ();
    sm_step_output_if #(.POS_W(S_W)) sbus ();

    sm_step_output #(.POS_W(32), .MIN_HIGH(MH), .MIN_LOW(ML),
                     .DIR_SETUP(DS), .EN_DELAY(ED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sm_step_output #(.POS_W(S_W), .MIN_HIGH(S_MH), .MIN_LOW(S_ML),
                     .DIR_SETUP(S_DS), .EN_DELAY(S_ED)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.step_in = 1'b1;
        tick(1);
        bus.step_in = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        si, dr, en;
        int          cyc;
        logic        e_step, e_en, e_dir, e_busy;
        logic [31:0] e_pos;
    } vec_t;

    vec_t tab[10];

    // Reference model for the small instance: tracks when the current step rises and
    // when the next launch becomes legal, instead of stepping through states.
    int          m_n, m_ready, m_rise, m_pend, m_drop;
    bit          m_en, m_flt, m_act, m_wake, m_sched, m_prev, m_h1, m_h2;
    logic        m_dir;
    logic [3:0]  m_pos;

    task automatic model_edge(input bit si, input bit dr, input bit er, input bit fn,
                              input bit fc, input bit cp);
        bit e, flt, upd;
        int req;
        e = si & ~m_prev;
        m_prev = si;
        flt = m_h2;
        m_h2 = m_h1;
        m_h1 = ~fn;
        upd = 1'b0;
        if (flt) begin
            m_flt = 1; m_en = 0; m_pend = 0; m_act = 0; m_sched = 0;
        end else if (m_flt) begin
            if (fc) m_flt = 0;
        end else if (!m_en) begin
            if (er) begin
                m_en = 1; m_wake = 1; m_act = 0; m_ready = m_n + S_ED + 1;
            end
        end else if (!er) begin
            m_en = 0; m_pend = 0; m_act = 0; m_sched = 0;
        end else begin
            if (m_sched && m_n == m_rise) begin
                upd = 1; m_sched = 0;
            end
            if (m_n >= m_ready) begin
                req = m_pend + int'(e);
                if (req > 0) begin
                    m_wake = 0;
                    m_act  = 1;
                    if (dr != m_dir) begin
                        m_dir = dr; m_rise = m_n + S_DS; m_sched = 1;
                    end else begin
                        m_rise = m_n; upd = 1;
                    end
                    m_ready = m_rise + S_MH + S_ML;
                    m_pend  = req - 1;
                end else begin
                    m_act = 0;
                end
            end else if (m_wake) begin
                if (e) m_pend = 1;
            end else if (e) begin
                if (m_pend > 0) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_pend = 1;
                end
            end
        end
        if (cp) m_pos = 4'd0;
        else if (upd) m_pos = m_dir ? m_pos + 4'd1 : m_pos - 4'd1;
    endtask

    initial begin
        int rise2;
        logic prev_step;
        bit r_si, r_dr, r_en, r_fn, r_fc, r_cp;
        bit e_step, e_busy;
        int shown;

        bus.step_in = 0; bus.dir_req = 0; bus.en_req = 0;
        bus.fault_n = 1; bus.fault_clr = 0; bus.clr_pos = 0;
        sbus.step_in = 0; sbus.dir_req = 0; sbus.en_req = 0;
        sbus.fault_n = 1; sbus.fault_clr = 0; sbus.clr_pos = 0;

        //              name          si dr en cyc     step en dir busy pos
        tab[0] = '{"en_rise",     0, 1, 1, 1,      0, 1, 0, 0, 32'd0};
        tab[1] = '{"wake_end",    0, 1, 1, ED-1,   0, 1, 0, 0, 32'd0};
        tab[2] = '{"idle_ready",  0, 1, 1, 100,    0, 1, 0, 0, 32'd0};
        tab[3] = '{"dir_set",     1, 1, 1, 1,      0, 1, 1, 1, 32'd0};
        tab[4] = '{"dir_set_end", 0, 1, 1, DS-1,   0, 1, 1, 1, 32'd0};
        tab[5] = '{"rise",        0, 1, 1, 1,      1, 1, 1, 1, 32'd1};
        tab[6] = '{"high_end",    0, 1, 1, MH-1,   1, 1, 1, 1, 32'd1};
        tab[7] = '{"fall",        0, 1, 1, 1,      0, 1, 1, 1, 32'd1};
        tab[8] = '{"low_end",     0, 1, 1, ML-1,   0, 1, 1, 1, 32'd1};
        tab[9] = '{"idle_again",  0, 1, 1, 1,      0, 1, 1, 0, 32'd1};

        rst = 1;
        tick(3);
        rst = 0;
        chk("rst_step", bus.step_out, 0);
        chk("rst_en", bus.en_out, 0);
        chk("rst_dir", bus.dir_out, 0);
        chk("rst_pos", bus.position, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        chk("rst_flt", bus.fault_latched, 0);
        chk("rst_busy", bus.busy, 0);

        for (int i = 0; i < 10; i++) begin
            bus.step_in = tab[i].si;
            bus.dir_req = tab[i].dr;
            bus.en_req  = tab[i].en;
            tick(tab[i].cyc);
            chk({tab[i].name, "_step"}, bus.step_out, tab[i].e_step);
            chk({tab[i].name, "_en"},   bus.en_out,   tab[i].e_en);
            chk({tab[i].name, "_dir"},  bus.dir_out,  tab[i].e_dir);
            chk({tab[i].name, "_busy"}, bus.busy,     tab[i].e_busy);
            chk({tab[i].name, "_pos"},  bus.position, tab[i].e_pos);
        end

        // Back-to-back: second edge pends, third is dropped.
        pulse();
        chk("b2b_first_rise", bus.step_out, 1);
        tick(19);
        pulse();
        tick(9);
        pulse();
        rise2 = -1;
        prev_step = bus.step_out;
        for (int k = 31; k <= 400; k++) begin
            tick(1);
            if (rise2 < 0 && bus.step_out && !prev_step) rise2 = k;
            prev_step = bus.step_out;
        end
        chk("b2b_period", rise2, 200);
        chk("b2b_drop", bus.drop_cnt, 1);
        chk("b2b_pos", bus.position, 3);
        chk("b2b_idle", bus.busy, 0);

        // Direction reversal.
        bus.dir_req = 0;
        pulse();
        chk("rev_dir", bus.dir_out, 0);
        chk("rev_step0", bus.step_out, 0);
        tick(DS-1);
        chk("rev_setup_step", bus.step_out, 0);
        chk("rev_setup_pos", bus.position, 3);
        tick(1);
        chk("rev_rise", bus.step_out, 1);
        chk("rev_pos", bus.position, 2);
        tick(MH+ML);
        chk("rev_idle", bus.busy, 0);

        // clr_pos beats the simultaneous -1.
        bus.clr_pos = 1;
        pulse();
        bus.clr_pos = 0;
        chk("clr_pos", bus.position, 0);
        chk("clr_step", bus.step_out, 1);
        tick(MH+ML);

        // Fault in mid-HIGH.
        pulse();
        chk("flt_pre_pos", bus.position, 32'hFFFF_FFFF);
        tick(30);
        bus.fault_n = 0;
        tick(2);
        chk("flt_sync_delay", bus.step_out, 1);
        tick(1);
        chk("flt_step", bus.step_out, 0);
        chk("flt_en", bus.en_out, 0);
        chk("flt_latch", bus.fault_latched, 1);
        chk("flt_dir_hold", bus.dir_out, 0);
        chk("flt_pos_hold", bus.position, 32'hFFFF_FFFF);
        bus.fault_clr = 1;
        tick(1);
        bus.fault_clr = 0;
        chk("flt_clr_ignored", bus.fault_latched, 1);
        bus.fault_n = 1;
        tick(3);
        chk("flt_still", bus.fault_latched, 1);
        bus.fault_clr = 1;
        tick(1);
        bus.fault_clr = 0;
        chk("flt_cleared", bus.fault_latched, 0);
        chk("flt_disabled_en", bus.en_out, 0);
        tick(1);
        chk("flt_rewake_en", bus.en_out, 1);

        // en_req falls mid-HIGH with a step pending.
        tick(ED);
        pulse();
        chk("dis_pos", bus.position, 32'hFFFF_FFFE);
        tick(5);
        pulse();
        chk("dis_pending", bus.busy, 1);
        tick(5);
        bus.en_req = 0;
        tick(1);
        chk("dis_step", bus.step_out, 0);
        chk("dis_en", bus.en_out, 0);
        chk("dis_busy", bus.busy, 0);
        for (int i = 0; i < 3; i++) begin
            pulse();
            tick(3);
        end
        chk("dis_drop", bus.drop_cnt, 1);
        chk("dis_pos_kept", bus.position, 32'hFFFF_FFFE);

        // Randomized traffic on the small instance.
        rst = 1;
        tick(2);
        rst = 0;
        m_n = 0; m_ready = 0; m_rise = 0; m_pend = 0; m_drop = 0;
        m_en = 0; m_flt = 0; m_act = 0; m_wake = 0; m_sched = 0;
        m_prev = 0; m_h1 = 0; m_h2 = 0; m_dir = 0; m_pos = 0;
        r_si = 0; r_dr = 0; r_en = 0; r_fn = 1; r_fc = 0; r_cp = 0;
        shown = 0;
        for (int c = 0; c < N_RAND; c++) begin
            if ($urandom_range(0, 3) == 0) r_si = ~r_si;
            if ($urandom_range(0, 39) == 0) r_dr = ~r_dr;
            if (r_en) begin
                if ($urandom_range(0, 299) == 0) r_en = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                r_en = 1;
            end
            if (r_fn) begin
                if ($urandom_range(0, 799) == 0) r_fn = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                r_fn = 1;
            end
            r_fc = ($urandom_range(0, 15) == 0);
            r_cp = ($urandom_range(0, 63) == 0);
            sbus.step_in = r_si; sbus.dir_req = r_dr; sbus.en_req = r_en;
            sbus.fault_n = r_fn; sbus.fault_clr = r_fc; sbus.clr_pos = r_cp;
            @(posedge clk);
            model_edge(r_si, r_dr, r_en, r_fn, r_fc, r_cp);
            #1;
            e_step = m_act && (m_n >= m_rise) && (m_n < m_rise + S_MH);
            e_busy = (m_act && (m_n < m_ready)) || (m_pend > 0);
            tests++;
            if (sbus.step_out !== e_step || sbus.en_out !== m_en || sbus.dir_out !== m_dir ||
                sbus.position !== m_pos || sbus.drop_cnt !== 8'(m_drop) ||
                sbus.fault_latched !== m_flt || sbus.busy !== e_busy) begin
                fails++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand cyc %0d: got step=%b en=%b dir=%b pos=%0h drop=%0d flt=%b busy=%b expected step=%b en=%b dir=%b pos=%0h drop=%0d flt=%b busy=%b",
                             m_n, sbus.step_out, sbus.en_out, sbus.dir_out, sbus.position,
                             sbus.drop_cnt, sbus.fault_latched, sbus.busy,
                             e_step, m_en, m_dir, m_pos, m_drop, m_flt, e_busy);
                end
            end
            m_n++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
